// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 3-sample majority vote and parity/framing flags.
// Defining UART_RX_BREAK_DETECT_EN adds o_Break and a line-idle wait after a break frame.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 13158,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic                 o_Break,
`endif
  output logic                 o_Busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int H = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_S0 = CW'(H - 1);
  localparam logic [CW-1:0] C_S1 = CW'(H);
  localparam logic [CW-1:0] C_V = CW'(H + 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_DONE, S_BRK} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q, smp_q, smp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, byte_q;
  logic perr_q, perr_d, ferr_q, ferr_d, zero_q, zero_d;
  logic dv_q, brk_q, perr_o_q, ferr_o_q;
  logic rx, at_v, at_b, vote, fin, brk_fr;
  assign rx = sync_q[1];
  assign at_v = cnt_q == C_V;
  assign at_b = cnt_q == C_LAST;
  assign vote = (smp_q[0] & smp_q[1]) | (rx & (smp_q[0] | smp_q[1]));
  // fin is the final stop-bit vote cycle; the frame completes here without waiting for the bit end
  assign fin = state_q == S_STOP && at_v && idx_q == STOP_LAST;
`ifdef UART_RX_BREAK_DETECT_EN
  assign brk_fr = zero_d;
  assign o_Break = brk_q;
`else
  assign brk_fr = 1'b0;
`endif
  assign o_Rx_DV = dv_q;
  assign o_Rx_Byte = byte_q;
  assign o_Parity_Err = perr_o_q;
  assign o_Frame_Err = ferr_o_q;
  assign o_Busy = state_q != S_IDLE;
  always_comb begin
    state_d = state_q;
    cnt_d = at_b || state_q == S_IDLE ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    smp_d = {cnt_q == C_S1 ? rx : smp_q[1], cnt_q == C_S0 ? rx : smp_q[0]};
    shift_d = shift_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    zero_d = zero_q & ~(at_v & vote);
    case (state_q)
      S_IDLE: if (!rx) begin
        state_d = S_START;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        zero_d = 1'b1;
      end
      S_START: begin
        idx_d = '0;
        if (at_v && vote) state_d = S_IDLE;
        else if (at_b) state_d = S_DATA;
      end
      S_DATA: begin
        if (at_v) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (at_b) begin
          idx_d = idx_q == DATA_LAST ? '0 : idx_q + 1'b1;
          if (idx_q == DATA_LAST) state_d = PARITY != 0 ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (at_v) perr_d = ^shift_q ^ vote ^ (PARITY == 1);
        if (at_b) state_d = S_STOP;
      end
      S_STOP: begin
        if (at_v) ferr_d = ferr_q | ~vote;
        if (fin) state_d = S_DONE;
        else if (at_b) idx_d = idx_q + 1'b1;
      end
      S_DONE: begin
        cnt_d = '0;
        state_d = brk_q ? S_BRK : S_IDLE;
      end
      S_BRK: begin
        // counts consecutive high cycles; any low cycle restarts the wait
        cnt_d = rx ? cnt_q + 1'b1 : '0;
        if (rx && at_b) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      sync_q <= 2'b11;
      smp_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      zero_q <= 1'b0;
      dv_q <= 1'b0;
      brk_q <= 1'b0;
      byte_q <= '0;
      perr_o_q <= 1'b0;
      ferr_o_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[0], i_Rx_Serial};
      smp_q <= smp_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      zero_q <= zero_d;
      dv_q <= fin & ~brk_fr;
      brk_q <= fin & brk_fr;
      if (fin && !brk_fr) begin
        byte_q <= shift_q;
        perr_o_q <= perr_q;
        ferr_o_q <= ferr_d;
      end
    end
  end
endmodule
